// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned BYTE_LANE_W = 8;
    localparam int unsigned LANE_SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        WR_MERGE = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Request fields latched at the accept edge.
    typedef struct packed {
        logic              write;
        logic              byte_acc;
        logic              err;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane extract (zero-extended) and merge, shared by byte loads and byte stores.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0]      word,
    input  logic [LANE_SEL_W-1:0]  lane,
    input  logic [BYTE_LANE_W-1:0] data,
    output logic [DATA_W-1:0]      extracted,
    output logic [DATA_W-1:0]      merged
);

    // Lane 0 is bits [7:0] (little-endian).
    always_comb begin
        extracted = '0;
        merged    = word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane == LANE_SEL_W'(i)) begin
                extracted = DATA_W'(word[i*BYTE_LANE_W +: BYTE_LANE_W]);
                merged[i*BYTE_LANE_W +: BYTE_LANE_W] = data;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a word-addressed data memory with byte RMW and error rejection.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd
);

    state_t            state;
    req_t              req_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_ext;
    logic [DATA_W-1:0] lane_merged;
    logic              req_err_c;

    assign req_err_c = ({2'b00, req_addr[DATA_W-1:2]} >= DEPTH) ||
                       (!req_byte && (req_addr[1:0] != 2'b00));

    byte_lane_unit u_lane (
        .word      (lane_word),
        .lane      (req_q.addr[LANE_SEL_W-1:0]),
        .data      (req_q.wdata[BYTE_LANE_W-1:0]),
        .extracted (lane_ext),
        .merged    (lane_merged)
    );

    // Memory port; write enable is masked by reset so an in-flight merge write is dropped.
    always_comb begin
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        lane_word = mem_rd;
        case (state)
            ACCESS: begin
                mem_a = {req_q.addr[DATA_W-1:2], 2'b00};
                if (!req_q.err && req_q.write && !req_q.byte_acc) begin
                    mem_wd = req_q.wdata;
                    mem_we = !reset;
                end
            end
            WR_MERGE: begin
                lane_word = merge_q;
                mem_a     = {req_q.addr[DATA_W-1:2], 2'b00};
                mem_wd    = lane_merged;
                mem_we    = !reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            merge_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q.write    <= req_write;
                        req_q.byte_acc <= req_byte;
                        req_q.err      <= req_err_c;
                        req_q.addr     <= req_addr;
                        req_q.wdata    <= req_wdata;
                        req_ready      <= 1'b0;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (req_q.err) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (req_q.write && req_q.byte_acc) begin
                        merge_q <= mem_rd;
                        state   <= WR_MERGE;
                    end else begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= req_q.write    ? '0 :
                                     req_q.byte_acc ? lane_ext : mem_rd;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WR_MERGE: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: response and memory-write queues checked by monitors.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [128];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          c0;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];

    mem_access_ctrl #(.DEPTH(128), .WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: combinational read, write on rising edge.
    assign mem_rd = mem[mem_a[8:2]];
    always @(posedge clk) if (mem_we === 1'b1) mem[mem_a[8:2]] <= mem_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: observed 0x%08h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Response monitor: compares every valid cycle against the head of the queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                fail_event("unexpected_rsp", rsp_rdata);
            end else begin
                check("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                check("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
                check("req_ready_busy", 32'(req_ready), 32'd0);
                if (rsp_q[0].lat >= 0) begin
                    check("rsp_latency", 32'(cyc - rsp_q[0].c0), 32'(rsp_q[0].lat));
                    rsp_q[0].lat = -1;
                end
                if (rsp_ready === 1'b1) void'(rsp_q.pop_front());
            end
        end
    end

    // Memory write monitor: each asserted write-enable cycle consumes one expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                fail_event("unexpected_write", mem_a);
            end else begin
                check("wr_addr", mem_a, wr_q[0].addr);
                check("wr_data", mem_wd, wr_q[0].data);
                void'(wr_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic w, input logic b, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat,
                         input logic exp_wr, input logic [31:0] wr_addr,
                         input logic [31:0] wr_data);
        rsp_exp_t r;
        wr_exp_t  x;
        wait_ready();
        req_valid = 1'b1; req_write = w; req_byte = b;
        req_addr = addr;  req_wdata = wdata;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = lat; r.c0 = cyc;
        rsp_q.push_back(r);
        if (exp_wr) begin
            x.addr = wr_addr; x.data = wr_data;
            wr_q.push_back(x);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 32'(rsp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
        check({tag, "_mem_a"},     mem_a,          32'd0);
        check({tag, "_mem_wd"},    mem_wd,         32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'h0BAD_F00D;
        mem[8]   = 32'h1122_3344;
        mem[12]  = 32'h8899_AABB;
        mem[16]  = 32'hCAFE_F00D;
        mem[127] = 32'h0102_0304;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Word store then load back.
        issue(1, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 32'h10, 32'hDEAD_BEEF);
        issue(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0);
        // Byte store RMW into lane 2, then word load.
        issue(1, 1, 32'h22, 32'h0000_00AA, 32'h0, 0, 3, 1, 32'h20, 32'h11AA_3344);
        issue(0, 0, 32'h20, 32'h0, 32'h11AA_3344, 0, 2, 0, 0, 0);
        // Byte loads across all four lanes.
        issue(0, 1, 32'h30, 32'h0, 32'h0000_00BB, 0, 2, 0, 0, 0);
        issue(0, 1, 32'h31, 32'h0, 32'h0000_00AA, 0, 2, 0, 0, 0);
        issue(0, 1, 32'h32, 32'h0, 32'h0000_0099, 0, 2, 0, 0, 0);
        issue(0, 1, 32'h33, 32'h0, 32'h0000_0088, 0, 2, 0, 0, 0);
        // Errors: misaligned word, out-of-range word store and byte load.
        issue(0, 0, 32'h06,  32'h0, 32'h0, 1, 2, 0, 0, 0);
        issue(1, 0, 32'h200, 32'h1234_5678, 32'h0, 1, 2, 0, 0, 0);
        issue(0, 1, 32'h203, 32'h0, 32'h0, 1, 2, 0, 0, 0);
        issue(0, 0, 32'h00,  32'h0, 32'h0BAD_F00D, 0, 2, 0, 0, 0);
        // Last byte of the memory.
        issue(1, 1, 32'h1FF, 32'h0000_0055, 32'h0, 0, 3, 1, 32'h1FC, 32'h5502_0304);
        issue(0, 0, 32'h1FC, 32'h0, 32'h5502_0304, 0, 2, 0, 0, 0);
        drain();

        // Backpressure with a stray request pulse during the hold.
        rsp_ready = 1'b0;
        issue(0, 0, 32'h30, 32'h0, 32'h8899_AABB, 0, 2, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_pending", 32'(rsp_q.size()), 32'd1);
        rsp_ready = 1'b1;
        drain();
        issue(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0);
        drain();

        // Reset during the merge-write cycle of a byte store.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
        req_addr = 32'h41; req_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_merge_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        check("midrst_word", mem[16], 32'hCAFE_F00D);
        reset = 1'b0;
        issue(0, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 2, 0, 0, 0);
        drain();

        repeat (2) @(posedge clk);
        #1;
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("final_word_10", mem[4], 32'hDEAD_BEEF);
        check("final_word_0", mem[0], 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
